systolic_matmul: RTL and testbench

SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

---
 rtl/systolic_matmul.sv | 121 ++++++++++++
 tb/tb_systolic_matmul.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_matmul.sv
// systolic_matmul: output-stationary N x N systolic array computing C = A*B or C += A*B.
// Define SYSTOLIC_MATMUL_SAT_EN to make every accumulate saturate instead of wrapping.
module systolic_matmul #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      accumulate,
    input  logic [N*N*DATA_W-1:0]     matrix_a,
    input  logic [N*N*DATA_W-1:0]     matrix_b,
    output logic [N*N*ACC_W-1:0]      matrix_c,
    output logic                      busy,
    output logic                      done
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam int TW = $clog2(3 * N - 2);
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    logic [1:0] state;
    logic [TW-1:0] t;
    logic signed [DATA_W-1:0] op_a [N*N];
    logic signed [DATA_W-1:0] op_b [N*N];
    logic signed [DATA_W-1:0] a_r [N*N];
    logic signed [DATA_W-1:0] b_r [N*N];
    logic signed [DATA_W-1:0] a_in [N*N];
    logic signed [DATA_W-1:0] b_in [N*N];
    logic signed [ACC_W-1:0] acc [N*N];
    logic signed [ACC_W-1:0] prod [N*N];
    logic signed [ACC_W-1:0] nxt [N*N];
`ifdef SYSTOLIC_MATMUL_SAT_EN
    logic signed [ACC_W:0] sum [N*N];
`endif

    assign busy = state != IDLE;
    assign done = state == DONE;

    // PE operand inputs: forwarded from the neighbour, or the skewed edge feed on row 0 / column 0
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_in[i*N+j] = (j > 0) ? a_r[i*N + (j > 0 ? j - 1 : 0)] : '0;
                b_in[i*N+j] = (i > 0) ? b_r[(i > 0 ? i - 1 : 0)*N + j] : '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(t) == i + k) begin
                    a_in[i*N] = op_a[i*N+k];
                    b_in[i] = op_b[k*N+i];
                end
            end
        end
    end

    // Per-PE multiply-accumulate; products are exact because ACC_W >= 2*DATA_W
    always_comb begin
        for (int p = 0; p < N*N; p++) begin
            prod[p] = ACC_W'(a_in[p]) * ACC_W'(b_in[p]);
`ifdef SYSTOLIC_MATMUL_SAT_EN
            sum[p] = (ACC_W+1)'(acc[p]) + (ACC_W+1)'(prod[p]);
            nxt[p] = (sum[p][ACC_W] != sum[p][ACC_W-1])
                   ? (sum[p][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                   : sum[p][ACC_W-1:0];
`else
            nxt[p] = acc[p] + prod[p];
`endif
        end
    end

    // Flatten the accumulators onto the row-major result bus
    always_comb begin
        for (int p = 0; p < N*N; p++) matrix_c[p*ACC_W +: ACC_W] = acc[p];
    end

    // Control FSM, step counter and operand capture on an accepted start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            t <= '0;
            for (int p = 0; p < N*N; p++) begin
                op_a[p] <= '0;
                op_b[p] <= '0;
            end
        end else if (state == IDLE) begin
            if (start) begin
                state <= RUN;
                for (int p = 0; p < N*N; p++) begin
                    op_a[p] <= matrix_a[p*DATA_W +: DATA_W];
                    op_b[p] <= matrix_b[p*DATA_W +: DATA_W];
                end
            end
        end else if (state == RUN) begin
            if (t == T_LAST) state <= DONE;
            else t <= t + TW'(1);
        end else begin
            state <= IDLE;
            t <= '0;
        end
    end

    // PE accumulators and a/b pipeline registers; pipeline is flushed outside RUN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < N*N; p++) begin
                acc[p] <= '0;
                a_r[p] <= '0;
                b_r[p] <= '0;
            end
        end else begin
            for (int p = 0; p < N*N; p++) begin
                a_r[p] <= (state == RUN) ? a_in[p] : '0;
                b_r[p] <= (state == RUN) ? b_in[p] : '0;
                if (state == RUN) acc[p] <= nxt[p];
                else if (state == IDLE && start && !accumulate) acc[p] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_systolic_matmul.sv
// tb_systolic_matmul: directed runs against a matrix-level model plus literal expectations.
module tb_systolic_matmul;
    localparam int N = 4, DW = 8, AW = 20, NN = N * N, LAST = 3 * N - 2;

    logic clk = 0, rst = 1, start = 0, accumulate = 0;
    logic [NN*DW-1:0] matrix_a = '0, matrix_b = '0;
    logic [NN*AW-1:0] matrix_c;
    logic busy, done;

    logic start2 = 0;
    logic [NN*DW-1:0] a2 = {NN{8'd127}}, b2 = {NN{8'd127}};
    logic [NN*16-1:0] c2;
    logic busy2, done2;

    logic start3 = 0;
    logic [4*DW-1:0] a3 = {4{8'h80}}, b3 = {4{8'h80}};
    logic [4*AW-1:0] c3;
    logic busy3, done3;

    int checks = 0, errors = 0;
    int ma [N][N];
    int mb [N][N];
    logic running = 0;
    int cnt = 0;
    logic [NN*AW-1:0] exp_c = '0, pending = '0;

    systolic_matmul #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
        .clock(clk), .reset(rst), .start(start), .accumulate(accumulate),
        .matrix_a(matrix_a), .matrix_b(matrix_b), .matrix_c(matrix_c), .busy(busy), .done(done));

    systolic_matmul #(.N(N), .DATA_W(DW), .ACC_W(16)) dut2 (
        .clock(clk), .reset(rst), .start(start2), .accumulate(1'b0),
        .matrix_a(a2), .matrix_b(b2), .matrix_c(c2), .busy(busy2), .done(done2));

    systolic_matmul #(.N(2), .DATA_W(DW), .ACC_W(AW)) dut3 (
        .clock(clk), .reset(rst), .start(start3), .accumulate(1'b0),
        .matrix_a(a3), .matrix_b(b3), .matrix_c(c3), .busy(busy3), .done(done3));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [NN*AW-1:0] act, input logic [NN*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic longint el(input logic [NN*AW-1:0] v, input int i, input int j);
        return longint'($signed(v[(i*N+j)*AW +: AW]));
    endfunction

    // C = (acc ? C : 0) + A*B with plain integer arithmetic, wrapped to AW bits
    function automatic logic [NN*AW-1:0] calc(input logic acc_f);
        logic [NN*AW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = acc_f ? int'(el(exp_c, i, j)) : 0;
                for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
                r[(i*N+j)*AW +: AW] = s[AW-1:0];
            end
        end
        return r;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                matrix_a[(i*N+k)*DW +: DW] = DW'(ma[i][k]);
                matrix_b[(i*N+k)*DW +: DW] = DW'(mb[i][k]);
            end
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                case (mode)
                    0: begin ma[i][k] = int'(i == k); mb[i][k] = 4 * i + k; end
                    1: begin ma[i][k] = 3; mb[i][k] = 3; end
                    2: begin ma[i][k] = 9 * (i * N + k) - 70; mb[i][k] = 50 - 7 * (i * N + k); end
                    3: begin ma[i][k] = 2; mb[i][k] = -5; end
                    4: ma[i][k] = 7;
                    default: begin ma[i][k] = int'(i == k); mb[i][k] = 1; end
                endcase
            end
        end
        pack();
    endtask

    // One clock edge: advance the model from the inputs seen at that edge, then step off the edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            running = 0;
            cnt = 0;
            exp_c = '0;
        end else if (running) begin
            cnt++;
            if (cnt == LAST + 1) begin
                running = 0;
                exp_c = pending;
            end
        end else if (start) begin
            running = 1;
            cnt = 0;
            pending = calc(accumulate);
        end
        #1;
    endtask

    task automatic set_reset(input logic v);
        rst = v;
        if (v) begin
            running = 0;
            cnt = 0;
            exp_c = '0;
        end
    endtask

    task automatic run(input logic acc_f);
        accumulate = acc_f;
        start = 1;
        tick();
        start = 0;
        repeat (LAST) tick();
    endtask

    // Main DUT checked against the model on every falling edge
    always @(negedge clk) begin
        chk("busy", busy, running);
        chk("done", done, running && cnt == LAST);
        if (!running || cnt == LAST) chkv("matrix_c", matrix_c, running ? pending : exp_c);
    end

    initial begin
        longint exp2;
        bit seen;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_c33", el(matrix_c, 3, 3), 0);

        fill(0);
        start = 1;
        tick();
        chk("start_in_reset", busy, 0);
        set_reset(0);
        tick();
        start = 0;
        chk("busy_e0", busy, 1);
        repeat (9) tick();
        chk("done_e10", done, 0);
        tick();
        chk("done_e11", done, 1);
        chk("ident_c30", el(matrix_c, 3, 0), 12);
        chk("ident_c12", el(matrix_c, 1, 2), 6);
        tick();
        chk("busy_fall", busy, 0);

        fill(1);
        run(0);
        chk("threes_c00", el(matrix_c, 0, 0), 36);
        tick();
        run(1);
        chk("threes_acc_c32", el(matrix_c, 3, 2), 72);
        tick();

        fill(2);
        run(0);
        chk("mixed_c00", el(matrix_c, 0, 0), -3068);
        tick();

        fill(3);
        accumulate = 0;
        start = 1;
        tick();
        start = 0;
        tick();
        fill(4);
        repeat (3) tick();
        start = 1;
        tick();
        start = 0;
        chk("restart_busy", busy, 1);
        repeat (5) tick();
        chk("restart_done", done, 1);
        chk("restart_c11", el(matrix_c, 1, 1), -40);
        tick();
        repeat (3) tick();

        fill(5);
        accumulate = 1;
        start = 1;
        tick();
        start = 0;
        repeat (6) tick();
        set_reset(1);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_c00", el(matrix_c, 0, 0), 0);
        repeat (2) tick();
        set_reset(0);
        tick();
        fill(0);
        run(1);
        chk("after_abort_c23", el(matrix_c, 2, 3), 11);
        tick();
        repeat (3) tick();

`ifdef SYSTOLIC_MATMUL_SAT_EN
        exp2 = 32767;
`else
        exp2 = -1020;
`endif
        start2 = 1;
        tick();
        start2 = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = done2;
        end
        chk("acc16_done_seen", seen, 1);
        for (int p = 0; p < NN; p++) chk("acc16_c", longint'($signed(c2[p*16 +: 16])), exp2);
        tick();

        for (int r = 0; r < 2; r++) begin
            b3 = (r == 0) ? {4{8'h80}} : {4{8'h7f}};
            start3 = 1;
            tick();
            start3 = 0;
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                seen = done3;
            end
            chk("n2_done_seen", seen, 1);
            for (int p = 0; p < 4; p++)
                chk("n2_c", longint'($signed(c3[p*AW +: AW])), (r == 0) ? 32768 : -32512);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
